// File: rtl/game_tick_sched.sv
// Clock-enable scheduler: free-running pix_en / sample_tick plus a game_tick whose
// period is set by a speed level, with RUN/PAUSED control. Define TICK_COUNT_EN for tick_count.
module game_tick_sched #(
    parameter int unsigned PIX_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned BASE_DIV   = 1000000,
    parameter int unsigned LEVEL_W    = 3,
    parameter int unsigned INIT_LEVEL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_toggle,
    input  logic               step_once,
    input  logic               speed_valid,
    input  logic [LEVEL_W-1:0] speed_level,
    output logic               speed_ready,
    output logic               pix_en,
    output logic               sample_tick,
    output logic               game_tick,
    output logic [LEVEL_W-1:0] cur_level,
    output logic               running
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0]        tick_count
`endif
);

    localparam int unsigned PIX_W    = $clog2(PIX_DIV);
    localparam int unsigned SAMPLE_W = $clog2(SAMPLE_DIV);
    localparam int unsigned BASE_W   = $clog2(BASE_DIV);

    typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} state_t;

    state_t               state, state_next;
    logic [PIX_W-1:0]     pix_cnt;
    logic [SAMPLE_W-1:0]  sample_cnt;
    logic [BASE_W-1:0]    pre_cnt;
    logic [LEVEL_W-1:0]   unit_cnt;
    logic [LEVEL_W-1:0]   last_unit;
    logic                 pending;
    logic [LEVEL_W-1:0]   pend_level;
    logic                 pre_last;
    logic                 terminal;
    logic                 tick_next;
    logic                 cnt_clear;
    logic                 cnt_adv;
    logic                 apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
            pix_en  <= 1'b0;
        end else if (pix_cnt == PIX_W'(PIX_DIV - 1)) begin
            pix_cnt <= '0;
            pix_en  <= 1'b1;
        end else begin
            pix_cnt <= pix_cnt + 1'b1;
            pix_en  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= '0;
            sample_tick <= 1'b0;
        end else if (sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1)) begin
            sample_cnt  <= '0;
            sample_tick <= 1'b1;
        end else begin
            sample_cnt  <= sample_cnt + 1'b1;
            sample_tick <= 1'b0;
        end
    end

    // LEVELS-1-cur_level in LEVEL_W bits is simply the bitwise complement.
    assign last_unit = ~cur_level;
    assign pre_last  = (pre_cnt == BASE_W'(BASE_DIV - 1));
    assign terminal  = (state == RUN) && pre_last && (unit_cnt == last_unit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PAUSED;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PAUSED:  if (pause_toggle) state_next = RUN;
            RUN:     if (pause_toggle) state_next = PAUSED;
            default: state_next = PAUSED;
        endcase
    end

    // The toggle cycle out of RUN already holds the counters unless it is the boundary.
    always_comb begin
        tick_next = 1'b0;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        apply     = 1'b0;
        case (state)
            PAUSED: begin
                if (pending) begin
                    apply     = 1'b1;
                    cnt_clear = 1'b1;
                end
                if (step_once && !pause_toggle) tick_next = 1'b1;
            end
            RUN: begin
                if (terminal) begin
                    tick_next = 1'b1;
                    cnt_clear = 1'b1;
                    apply     = pending;
                end else if (!pause_toggle) begin
                    cnt_adv = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            unit_cnt <= '0;
        end else if (cnt_clear) begin
            pre_cnt  <= '0;
            unit_cnt <= '0;
        end else if (cnt_adv) begin
            if (pre_last) begin
                pre_cnt  <= '0;
                unit_cnt <= unit_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_tick  <= 1'b0;
            pending    <= 1'b0;
            pend_level <= '0;
            cur_level  <= LEVEL_W'(INIT_LEVEL);
        end else begin
            game_tick <= tick_next;
            if (apply) begin
                cur_level <= pend_level;
                pending   <= 1'b0;
            end else if (speed_valid && !pending) begin
                pending    <= 1'b1;
                pend_level <= speed_level;
            end
        end
    end

`ifdef TICK_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            tick_count <= '0;
        else if (tick_next) tick_count <= tick_count + 1'b1;
    end
`endif

    assign speed_ready = ~pending;
    assign running     = (state == RUN);

endmodule
